// File: rtl/image_loader.sv
// Serial image loader: a SYNC_BYTE header followed by PIX_COUNT two-byte pixels,
// written out as 12-bit RGB. Define IMAGE_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module image_loader #(
  parameter int         PIX_COUNT = 4096,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        abort,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, HI, LO, CHK} state_t;

  state_t      state, state_nxt;
  logic [11:0] pix_cnt;
  logic [7:0]  rg_p0;
  logic        last_pix;
  logic        abort_eff;
  logic        take;

  assign last_pix  = (pix_cnt == 12'(PIX_COUNT - 1));
  assign abort_eff = abort && (state != IDLE);
  assign take      = rx_valid && !abort_eff;
  assign busy      = (state != IDLE);

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;
  assign err = err_q;
`else
  logic       fin_p1;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_eff) begin
      state_nxt = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE:    if (rx_data == SYNC_BYTE) state_nxt = HI;
        HI:      state_nxt = LO;
`ifdef IMAGE_LOADER_CHECKSUM_EN
        LO:      state_nxt = last_pix ? CHK : HI;
`else
        LO:      state_nxt = last_pix ? IDLE : HI;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: hold the {R,G} byte until its partner LO byte arrives
  always_ff @(posedge clk) begin
    if (take && state == HI) rg_p0 <= rx_data;
  end

  // Stage p1: registered write strobe, pixel index and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      csum    <= '0;
      err_q   <= 1'b0;
`else
      fin_p1  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      done  <= 1'b0;
`else
      done   <= fin_p1;
      fin_p1 <= 1'b0;
`endif
      if (take) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              pix_cnt <= '0;
              wr_addr <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
              csum    <= '0;
              err_q   <= 1'b0;
`endif
            end
          end
          HI: begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          LO: begin
            wr_en   <= 1'b1;
            wr_addr <= pix_cnt;
            wr_data <= {rg_p0, rx_data[3:0]};
            pix_cnt <= pix_cnt + 12'd1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            csum    <= csum ^ rx_data;
`else
            fin_p1  <= last_pix;
`endif
          end
          default: begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
            err_q <= (rx_data != csum);
            done  <= 1'b1;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: a byte-stream reference model predicts each write and
// done pulse with the cycle it must appear in; a monitor compares what the DUT presents.
module tb_image_loader;

  localparam int         PC   = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        abort;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  image_loader #(.PIX_COUNT(PC), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    logic [11:0] addr;
    logic [11:0] data;
  } wr_item_t;

  wr_item_t wq[$];
  int       dq[$];
  int       cyc = 0;
  int       checks = 0;
  int       failures = 0;

  // Reference model state: byte stream view of the current load
  bit         in_load = 0;
  bit         in_chk  = 0;
  int         nbytes  = 0;
  logic [7:0] rg_m    = 0;
  logic [7:0] csum_m  = 0;
  logic       err_m   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Drive one cycle of inputs and advance the model to the state after the next edge
  task automatic send(input logic v, input logic [7:0] d, input logic ab);
    int n;
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    abort    = ab;
    n = cyc + 1;
    if (ab && in_load) begin
      in_load = 0;
      in_chk  = 0;
    end else if (v) begin
      if (!in_load) begin
        if (d == SYNC) begin
          in_load = 1;
          nbytes  = 0;
          csum_m  = 0;
          err_m   = 0;
        end
      end else if (in_chk) begin
        err_m   = (d != csum_m);
        in_load = 0;
        in_chk  = 0;
        dq.push_back(n);
      end else begin
        csum_m = csum_m ^ d;
        if (nbytes % 2 == 0) begin
          rg_m = d;
        end else begin
          wq.push_back('{stamp: n, addr: 12'(nbytes / 2), data: {rg_m, d[3:0]}});
          if (nbytes / 2 == PC - 1) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
            in_chk = 1;
`else
            in_load = 0;
            dq.push_back(n + 1);
`endif
          end
        end
        nbytes++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(1'b1, b[i], 1'b0);
    end
  endtask

  // Complete load with random pixels; a bad checksum is sent when asked
  task automatic send_load(input bit bad);
    logic [7:0] b[$];
    logic [7:0] x;
    x = 0;
    b.push_back(SYNC);
    for (int i = 0; i < 2 * PC; i++) begin
      b.push_back(8'($urandom));
      x = x ^ b[$];
    end
`ifdef IMAGE_LOADER_CHECKSUM_EN
    b.push_back(bad ? x ^ 8'h3C : x);
`endif
    send_bytes(b);
  endtask

  function automatic logic [7:0] xor_tail(input logic [7:0] b[$]);
    logic [7:0] x;
    x = 0;
    for (int i = 1; i < b.size(); i++) x = x ^ b[i];
    return x;
  endfunction

  task automatic reset_now();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    wq.delete();
    dq.delete();
    in_load = 0;
    in_chk  = 0;
    err_m   = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: outputs are compared 2 time units after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (wq.size() > 0 && wq[0].stamp == cyc) begin
        chk("wr_en", 32'(wr_en), 1);
        chk("wr_addr", 32'(wr_addr), 32'(wq[0].addr));
        chk("wr_data", 32'(wr_data), 32'(wq[0].data));
        void'(wq.pop_front());
      end else begin
        chk("wr_en_idle", 32'(wr_en), 0);
      end
      if (dq.size() > 0 && dq[0] == cyc) begin
        chk("done", 32'(done), 1);
        void'(dq.pop_front());
      end else begin
        chk("done_idle", 32'(done), 0);
      end
      chk("busy", 32'(busy), 32'(in_load));
      chk("err", 32'(err), 32'(err_m));
    end
  end

  initial begin
    logic [7:0] b[$];
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    abort    = 1'b0;
    rst      = 1'b1;
    #1;
    chk("init_busy", 32'(busy), 0);
    chk("init_wr_en", 32'(wr_en), 0);
    chk("init_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Reference example load
    b = '{8'hA5, 8'h12, 8'h03, 8'h45, 8'h06, 8'h78, 8'h09, 8'hAB, 8'h0C};
`ifdef IMAGE_LOADER_CHECKSUM_EN
    b.push_back(xor_tail(b));
`endif
    send_bytes(b);
    idle(3);

    // Noise before header, SYNC value inside pixel data
    b = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
`ifdef IMAGE_LOADER_CHECKSUM_EN
    b.push_back(xor_tail(b[2:$]) ^ 8'h01);
`endif
    send_bytes(b);
    idle(3);

    // Abort together with the LO byte of pixel 2, then a fresh load
    send_bytes('{8'hA5, 8'h10, 8'h01, 8'h20, 8'h02, 8'h30});
    send(1'b1, 8'h03, 1'b1);
    idle(3);
    send(1'b0, 8'h00, 1'b1);
    send_load(0);
    idle(3);

    // Header together with abort while idle is still accepted
    send(1'b1, SYNC, 1'b1);
    send_bytes('{8'h9A, 8'hBC});
    idle(1);
    send(1'b0, 8'h00, 1'b1);

    // Reset during HI with gaps, then stray bytes, then a clean load
    send_bytes('{8'hA5, 8'h77, 8'h01});
    idle(2);
    reset_now();
    send_bytes('{8'h12, 8'h34, 8'h56, 8'h78});
    idle(2);
    send_load(0);
    idle(3);
    send_load(1);
    idle(3);
    send_load(0);
    idle(3);

    // Randomized stream with frequent headers, gaps and rare aborts
    for (int i = 0; i < 600; i++) begin
      send($urandom_range(0, 2) != 0,
           ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom),
           $urandom_range(0, 39) == 0);
    end
    send(1'b0, 8'h00, 1'b1);
    idle(6);

    chk("writes_left", 32'(wq.size()), 0);
    chk("dones_left", 32'(dq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
